add_sub_pipe: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor for the booth datapath and later arithmetic blocks; it generalises the fixed 8-bit combinational adder. The carry chain is split into `STAGES` registered segments. Valid/ready handshakes sit on input and output, and the block flags carry-out, signed overflow and zero.

---
 rtl/adder_pkg.sv | 15 +
 rtl/adder_seg.sv | 21 ++
 rtl/add_sub_pipe.sv | 126 ++++++++++++
 tb/tb_add_sub_pipe.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined add/sub datapath.
// Holds the operation encoding and the signed-overflow rule.
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Signed overflow: the carry into the MSB disagrees with the carry out of it.
    function automatic logic calc_ovf(input logic c_into_msb, input logic c_out_msb);
        return c_into_msb ^ c_out_msb;
    endfunction

endpackage

// File: rtl/adder_seg.sv
// Combinational SEG-bit ripple slice: sum, carry-out and carry into the slice MSB.
// No state, no latency, no handshake.
module adder_seg #(
    parameter int SEG = 8
) (
    input  logic           cin,
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           c_msb
);
    logic [SEG:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
    assign sum    = w_full[SEG-1:0];
    assign cout   = w_full[SEG];
    // The MSB sum bit is a ^ b ^ carry-in, so the carry into it falls out directly.
    assign c_msb  = a[SEG-1] ^ b[SEG-1] ^ w_full[SEG-1];

endmodule

// File: rtl/add_sub_pipe.sv
// Two's-complement add/sub with the carry chain cut into STAGES registered segments; latency STAGES edges, 1 op/cycle.
// One global enable (!out_valid | out_ready) freezes every stage while the output is stalled; in_ready follows it.
module add_sub_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  op_e              op,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int SEG = WIDTH / STAGES;

    if ((WIDTH % STAGES) != 0) begin : g_bad_params
        $error("add_sub_pipe: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
    end

    logic             w_en;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;
    logic             r_ovf;

    assign w_en      = !out_valid || out_ready;
    assign in_ready  = w_en;
    // Subtract as a + ~b + !cin so every stage is a plain adder and cout is the raw carry.
    assign w_b_eff   = (op == OP_SUB) ? ~b : b;
    assign w_cin_eff = (op == OP_SUB) ? !cin : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SEG;
        localparam int HI = LO + SEG;

        logic [WIDTH-1:LO] w_a_rest;
        logic [WIDTH-1:LO] w_b_rest;
        logic [HI-1:0]     w_s_nxt;
        logic              w_c_in;
        logic              w_v_in;
        logic [SEG-1:0]    w_seg_sum;
        logic              w_seg_cout;
        logic              w_seg_cmsb;
        logic [HI-1:0]     r_s;
        logic              r_c;
        logic              r_v;

        if (k == 0) begin : g_in
            assign w_a_rest = a;
            assign w_b_rest = w_b_eff;
            assign w_c_in   = w_cin_eff;
            assign w_v_in   = in_valid && w_en;
            assign w_s_nxt  = w_seg_sum;
        end else begin : g_in
            assign w_a_rest = g_stage[k-1].g_fwd.r_a;
            assign w_b_rest = g_stage[k-1].g_fwd.r_b;
            assign w_c_in   = g_stage[k-1].r_c;
            assign w_v_in   = g_stage[k-1].r_v;
            assign w_s_nxt  = {w_seg_sum, g_stage[k-1].r_s};
        end

        adder_seg #(.SEG(SEG)) u_seg (
            .cin   (w_c_in),
            .a     (w_a_rest[HI-1:LO]),
            .b     (w_b_rest[HI-1:LO]),
            .sum   (w_seg_sum),
            .cout  (w_seg_cout),
            .c_msb (w_seg_cmsb)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_s <= '0;
            end else if (w_en) begin
                r_v <= w_v_in;
                r_c <= w_seg_cout;
                r_s <= w_s_nxt;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [WIDTH-1:HI] r_a;
            logic [WIDTH-1:HI] r_b;
            logic              w_unused_cmsb;

            // Carry into an inner segment MSB says nothing about signed overflow.
            assign w_unused_cmsb = w_seg_cmsb;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_en) begin
                    r_a <= w_a_rest[WIDTH-1:HI];
                    r_b <= w_b_rest[WIDTH-1:HI];
                end
            end
        end else begin : g_out
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (w_en) begin
                    r_ovf <= calc_ovf(w_seg_cmsb, w_seg_cout);
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].r_v;
    assign sum       = g_stage[STAGES-1].r_s;
    assign cout      = g_stage[STAGES-1].r_c;
    assign ovf       = r_ovf;
    assign zero      = (sum == '0);

endmodule

// File: tb/tb_add_sub_pipe.sv
// Scoreboard bench for add_sub_pipe: directed vectors with hand-computed results,
// random output backpressure, plus 16/4 and 8/1 instances for latency and mid-flight reset.
module tb_add_sub_pipe;
    import adder_pkg::*;

    typedef struct {
        op_e         op;
        logic        cin;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        cin = 1'b0;
    logic        out_ready = 1'b0;
    op_e         op = OP_ADD;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [7:0]  a8;
    logic [7:0]  b8;

    logic        in_ready, out_valid, cout, ovf, zero;
    logic [15:0] sum;
    logic        in_ready4, out_valid4, cout4, ovf4, zero4;
    logic [15:0] sum4;
    logic        in_ready8, out_valid8, cout8, ovf8, zero8;
    logic [7:0]  sum8;

    exp_t q[$];
    vec_t dir_v[$];
    vec_t str_v[$];
    int   n_chk = 0;
    int   n_fail = 0;
    logic rand_rdy = 1'b0;

    assign a8 = a[7:0];
    assign b8 = b[7:0];

    always #5 clk = ~clk;

    add_sub_pipe #(.WIDTH(16), .STAGES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .cin(cin), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    add_sub_pipe #(.WIDTH(16), .STAGES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .op(op), .cin(cin), .a(a), .b(b),
        .out_valid(out_valid4), .out_ready(out_ready),
        .sum(sum4), .cout(cout4), .ovf(ovf4), .zero(zero4)
    );

    add_sub_pipe #(.WIDTH(8), .STAGES(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
        .op(op), .cin(cin), .a(a8), .b(b8),
        .out_valid(out_valid8), .out_ready(out_ready),
        .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present one operand set and hold it until accepted; queue its result if requested.
    task automatic send(input vec_t v, input bit push);
        logic acc;
        acc = 1'b0;
        @(posedge clk); #1;
        op = v.op; cin = v.cin; a = v.a; b = v.b; in_valid = 1'b1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        for (int n = 0; n < 64 && !acc; n++) begin
            if (n > 0) begin
                @(posedge clk); #1;
                if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (in_ready) acc = 1'b1;
        end
        chk("accept", acc, 1);
        if (acc && push) q.push_back('{v.s, v.co, v.ov});
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int   lat4, lat8;
        logic [15:0] s4;
        logic [7:0]  s8;
        logic c8, z8, drained, seen, seen4, seen8;

        dir_v.push_back('{OP_ADD, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1});
        dir_v.push_back('{OP_SUB, 1'b0, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0});
        dir_v.push_back('{OP_SUB, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1});
        dir_v.push_back('{OP_ADD, 1'b1, 16'h00FF, 16'h0000, 16'h0100, 1'b0, 1'b0});
        dir_v.push_back('{OP_ADD, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0});

        str_v.push_back('{OP_ADD, 1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0});
        str_v.push_back('{OP_SUB, 1'b0, 16'h1000, 16'h0001, 16'h0FFF, 1'b1, 1'b0});
        str_v.push_back('{OP_ADD, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1});
        str_v.push_back('{OP_SUB, 1'b1, 16'h0005, 16'h0005, 16'hFFFF, 1'b0, 1'b0});
        str_v.push_back('{OP_ADD, 1'b0, 16'h00F0, 16'h0F10, 16'h1000, 1'b0, 1'b0});
        str_v.push_back('{OP_SUB, 1'b0, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b0, 1'b1});
        str_v.push_back('{OP_ADD, 1'b1, 16'h4000, 16'h4000, 16'h8001, 1'b0, 1'b1});
        str_v.push_back('{OP_SUB, 1'b0, 16'hABCD, 16'h1234, 16'h9999, 1'b1, 1'b0});

        fork
            begin : monitor
                exp_t        e;
                logic        prev_stall;
                logic [15:0] ps;
                logic        pc, po;
                prev_stall = 1'b0;
                ps = '0; pc = 1'b0; po = 1'b0;
                forever begin
                    @(negedge clk);
                    if (!rst_n) begin
                        prev_stall = 1'b0;
                    end else begin
                        chk("in_ready_rule", in_ready, !out_valid || out_ready);
                        if (prev_stall) begin
                            chk("stall_valid", out_valid, 1);
                            chk("stall_sum", sum, ps);
                            chk("stall_cout", cout, pc);
                            chk("stall_ovf", ovf, po);
                        end
                        if (out_valid && out_ready) begin
                            chk("out_expected", 32'(q.size() != 0), 1);
                            if (q.size() != 0) begin
                                e = q.pop_front();
                                chk("sum", sum, e.sum);
                                chk("cout", cout, e.cout);
                                chk("ovf", ovf, e.ovf);
                                chk("zero", zero, e.sum == 16'h0000);
                            end
                        end
                        prev_stall = out_valid && !out_ready;
                        ps = sum; pc = cout; po = ovf;
                    end
                end
            end
        join_none

        fork
            begin : watchdog
                #200us;
                $display("FAIL watchdog: simulation did not complete");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset held with a valid operand presented.
        rst_n = 1'b0; in_valid = 1'b1; a = 16'h1234; b = 16'h1111; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_sum", sum, 16'h0000);
        chk("reset_zero", zero, 1);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_cout", cout, 0);
        chk("reset_ovf", ovf, 0);
        chk("reset_out_valid4", out_valid4, 0);
        chk("reset_out_valid8", out_valid8, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_idle", out_valid, 0);
        end

        // One op through all three depths: latency and cross-segment carry.
        send('{OP_ADD, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0}, 1);
        idle();
        lat4 = 0; lat8 = 0; s4 = '0; s8 = '0; c8 = 1'b0; z8 = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (out_valid8 && lat8 == 0) begin
                lat8 = n; s8 = sum8; c8 = cout8; z8 = zero8;
            end
            if (out_valid4 && lat4 == 0) begin
                lat4 = n; s4 = sum4;
            end
        end
        chk("lat_stages1", lat8, 1);
        chk("sum_w8", s8, 8'h00);
        chk("cout_w8", c8, 1);
        chk("zero_w8", z8, 1);
        chk("lat_stages4", lat4, 4);
        chk("sum_stages4", s4, 16'h0100);

        // Latency of the main instance on the overflow vector.
        send(dir_v[0], 1);
        idle();
        @(negedge clk);
        chk("lat_after_edge1", out_valid, 0);
        @(negedge clk);
        chk("lat_after_edge2", out_valid, 1);

        foreach (dir_v[i]) if (i > 0) send(dir_v[i], 1);
        idle();
        repeat (4) @(negedge clk);

        // Back-to-back stream under random output backpressure.
        rand_rdy = 1'b1;
        foreach (str_v[i]) send(str_v[i], 1);
        idle();
        drained = 1'b0;
        for (int n = 0; n < 100 && !drained; n++) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (q.size() == 0) drained = 1'b1;
        end
        chk("drain", drained, 1);
        rand_rdy = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("queue_empty", q.size(), 0);

        // Reset with two ops in flight; neither may ever appear.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send('{OP_ADD, 1'b0, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0}, 0);
        send('{OP_SUB, 1'b0, 16'h0010, 16'h0001, 16'h000F, 1'b1, 1'b0}, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2;
        chk("midflight_pre_valid", out_valid, 1);
        chk("midflight_pre_valid8", out_valid8, 1);
        rst_n = 1'b0;
        #1;
        chk("midflight_drop", out_valid, 0);
        chk("midflight_drop4", out_valid4, 0);
        chk("midflight_drop8", out_valid8, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 1'b0; seen4 = 1'b0; seen8 = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            seen  = seen  | out_valid;
            seen4 = seen4 | out_valid4;
            seen8 = seen8 | out_valid8;
        end
        chk("midflight_no_out", seen, 0);
        chk("midflight_no_out4", seen4, 0);
        chk("midflight_no_out8", seen8, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
